frame_buffer: RTL and testbench
===============================

# frame_buffer

Pixel store sitting directly downstream of the sprite command controller. It holds one 256x256 frame of 24-bit RGB pixels. A single-pixel write port is driven by `fb_wfb`/`fb_px`/`fb_r/g/b`. On `fb_dfb` it streams the whole frame, in raster order, to the display side over a valid/ready interface, holding `fb_busy` high until the last pixel is accepted.

## Interface
Parameters:
- `X_BITS`, default 8, column address width (frame width = 2^X_BITS)
- `Y_BITS`, default 8, row address width (frame height = 2^Y_BITS)
- `COLOR_BITS`, default 8, width of each colour channel

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `fb_wfb`  in  1  write one pixel this cycle
- `fb_dfb`  in  1  start frame dump (pulse)
- `fb_px`  in  X_BITS+Y_BITS  pixel address `{y, x}`
- `fb_r`, `fb_g`, `fb_b`  in  COLOR_BITS each  write colour
- `fb_busy`  out  1  dump in progress
- `disp_valid`  out  1  display pixel valid
- `disp_ready`  in  1  display sink accepts pixel
- `disp_px`  out  X_BITS+Y_BITS  address of presented pixel
- `disp_r`, `disp_g`, `disp_b`  out  COLOR_BITS each  presented colour
- `disp_last`  out  1  presented pixel is address all-ones

## Operation
- Storage: 2^(X_BITS+Y_BITS) x 3*COLOR_BITS simple dual-port RAM. It has one write port and one registered read port, read-first on a same-address collision. Reset does not clear contents.
- Write: `fb_wfb`=1 at an edge stores `{fb_r,fb_g,fb_b}` at `fb_px`. Writes are accepted in every state, including during a dump.
- Dump FSM states:
  - IDLE -> DUMP when `fb_dfb` is sampled 1.
  - DUMP: the read counter `rd_addr` starts at 0. A read is issued whenever the output buffer has space, and `rd_addr` increments by 1 per issued read. Reads stop after address all-ones.
  - DUMP -> IDLE on the handshake (`disp_valid`&`disp_ready`) of the pixel with `disp_last`=1.
- `fb_dfb` sampled while in DUMP is ignored and does not restart the dump.
- Order: `disp_px` runs 0,1,2,...; x is fastest (`{y,x}`). `disp_last` = (`disp_px` == all-ones) & `disp_valid`.
- Handshake: once `disp_valid` is high, `disp_px`/`disp_r/g/b` hold stable until accepted. `disp_valid` never drops without a handshake. The sink may hold `disp_ready` low indefinitely, with no pixel lost or duplicated.
- Write during dump:
  - Target address not yet read: the new value appears in this dump.
  - Target address already read: the new value appears only in the next dump.
  - Same-cycle write and read of one address: the old value is output.
- Simultaneous `fb_wfb` and `fb_dfb`: the write lands at the same edge, so the dump shows it.

## Timing
- Reset values: `fb_busy`=0, `disp_valid`=0, `disp_last`=0, `disp_px`=0, `disp_r/g/b`=0. The FSM goes to IDLE, `rd_addr`=0, and the output buffer is emptied.
- Reset mid-dump aborts immediately with no further `disp_valid`.
- `fb_busy` is registered. It rises in the cycle after the edge that samples `fb_dfb`. This is required: the upstream controller checks `fb_busy` one cycle after pulsing `fb_dfb`.
- Latency: with `fb_dfb` sampled at edge E0, the first read issues in cycle 1 and pixel 0 is presented in cycle 2.
- With `disp_ready` held at 1, pixel k is presented in cycle 2+k, i.e. 1 pixel/clock.
- `fb_busy` falls in the cycle after the `disp_last` handshake. With `disp_ready`=1 throughout, `fb_busy` is high for exactly 2^(X_BITS+Y_BITS)+1 cycles (65537 at defaults).
- Backpressure: the RAM read has 1-cycle latency, so a 2-entry output buffer is required to sustain full rate under `disp_ready` toggling. A read is issued only if (entries held + reads in flight) < 2.
- Address arithmetic: `rd_addr` is X_BITS+Y_BITS+1 bits wide so that the end-of-frame condition is detectable without wrap ambiguity.

## Structure
- Shared constants package: default frame dimensions and colour width (consumed by the sprite controller too), and the dump FSM `typedef enum {IDLE, DUMP}`.
- One sub-module: `pixel_skid_buffer`, a 2-entry valid/ready FIFO with `count` output, carrying `{px, rgb}`. The RAM is an inferred array inside `frame_buffer`.

## Test plan
- Reset, then write px 16'h0000=FF0000, 16'h00FF=00FF00, 16'hFFFF=0000FF, then `fb_dfb`, `disp_ready`=1 -> `fb_busy` high next cycle. Those three pixels come out at cycles 2, 257, 65537 with matching colour; `disp_last` only on 16'hFFFF; busy for 65537 cycles.
- Dump with `disp_ready` toggling 1,0,0,1 pattern -> every address 0..65535 output exactly once, in order; data stable while ready=0.
- `fb_dfb` pulsed again mid-dump at pixel 100 -> ignored; total handshakes = 65536; busy drops once.
- Write 16'h8000=123456 at pixel 10 of a dump -> dump shows 123456 at 16'h8000. Write 16'h0005=ABCDEF at pixel 10 -> old value at 16'h0005; next dump shows ABCDEF.
- Same-cycle `fb_wfb` (px 0, 777777) and `fb_dfb` -> first dumped pixel is 777777.
- Assert `rst_n`=0 at pixel 500 -> outputs 0 asynchronously. After release, no `disp_valid` until a new `fb_dfb`; RAM retains earlier writes.

Source files
------------

// File: rtl/frame_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : frame_buffer_pkg
// Description : Frame dimensions, colour width and dump FSM state encoding
//               shared by the frame buffer and the sprite command controller.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_buffer_pkg;

  // Default frame geometry: 256x256 pixels, 8 bits per colour channel
  localparam int c_x_bits     = 8;
  localparam int c_y_bits     = 8;
  localparam int c_color_bits = 8;

  // Frame dump controller states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DUMP = 1'b1
  } dump_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_buffer_pixel_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_skid_buffer
// Description : 2-entry fall-through valid/ready FIFO. When empty, incoming
//               data is presented in the same cycle so a 1-cycle RAM read can
//               stream at full rate; otherwise the oldest entry is shown.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;

  // Input goes straight through when empty and accepted, otherwise it is stored
  always_comb begin
    w_bypass = (r_count == 2'd0) && i_valid && i_ready;
    w_push   = i_valid && !w_bypass && (r_count != 2'd2);
    w_pop    = (r_count != 2'd0) && i_ready;
    o_valid  = (r_count != 2'd0) || i_valid;
    if (r_count != 2'd0) begin
      o_data = r_mem[r_rd_ptr];
    end else if (i_valid) begin
      o_data = i_data;
    end else begin
      o_data = '0;
    end
    o_count = r_count;
  end

  // Entry storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer
// Description : Single-frame RGB pixel store with a one-pixel write port and a
//               raster-order frame dump over a valid/ready display interface.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer
  import frame_buffer_pkg::*;
#(
  parameter int X_BITS     = c_x_bits,
  parameter int Y_BITS     = c_y_bits,
  parameter int COLOR_BITS = c_color_bits
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fb_wfb,
  input  logic                     fb_dfb,
  input  logic [X_BITS+Y_BITS-1:0] fb_px,
  input  logic [COLOR_BITS-1:0]    fb_r,
  input  logic [COLOR_BITS-1:0]    fb_g,
  input  logic [COLOR_BITS-1:0]    fb_b,
  output logic                     fb_busy,
  output logic                     disp_valid,
  input  logic                     disp_ready,
  output logic [X_BITS+Y_BITS-1:0] disp_px,
  output logic [COLOR_BITS-1:0]    disp_r,
  output logic [COLOR_BITS-1:0]    disp_g,
  output logic [COLOR_BITS-1:0]    disp_b,
  output logic                     disp_last
);

  localparam int c_aw    = X_BITS + Y_BITS;
  localparam int c_dw    = 3 * COLOR_BITS;
  localparam int c_depth = 1 << c_aw;

  logic [c_dw-1:0]      r_mem [c_depth];
  dump_state_t          r_state;
  logic                 r_busy;
  // One extra bit so "past the last address" is distinct from address 0
  logic [c_aw:0]        r_rd_addr;
  logic                 r_rd_vld;
  logic [c_aw-1:0]      r_rd_px;
  logic [c_dw-1:0]      r_rd_data;
  logic                 w_issue;
  logic                 w_hs_last;
  logic [1:0]           w_count;
  logic                 w_out_valid;
  logic [c_aw+c_dw-1:0] w_out_data;

  // Read only while the buffer plus the in-flight read leave a free slot
  always_comb begin
    w_issue   = (r_state == DUMP) && !r_rd_addr[c_aw] &&
                ((w_count + {1'b0, r_rd_vld}) < 2'd2);
    w_hs_last = disp_valid && disp_ready && disp_last;
  end

  // Pixel write port; fires in any state
  always_ff @(posedge clk) begin
    if (fb_wfb) begin
      r_mem[fb_px] <= {fb_r, fb_g, fb_b};
    end
  end

  // Registered read port; non-blocking update gives read-first on collision
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_rd_data <= r_mem[r_rd_addr[c_aw-1:0]];
    end
  end

  // Tracks the read in flight and the address it belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld <= 1'b0;
      r_rd_px  <= '0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_issue) begin
        r_rd_px <= r_rd_addr[c_aw-1:0];
      end
    end
  end

  // Dump controller: starts on fb_dfb, ends on the last pixel handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (fb_dfb) begin
            r_state   <= DUMP;
            r_busy    <= 1'b1;
            r_rd_addr <= '0;
          end
        end
        DUMP: begin
          if (w_issue) begin
            r_rd_addr <= r_rd_addr + {{c_aw{1'b0}}, 1'b1};
          end
          if (w_hs_last) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_rd_addr <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  pixel_skid_buffer #(
    .WIDTH(c_aw + c_dw)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_rd_vld),
    .i_data  ({r_rd_px, r_rd_data}),
    .o_valid (w_out_valid),
    .i_ready (disp_ready),
    .o_data  (w_out_data),
    .o_count (w_count)
  );

  // Unpack the presented entry onto the display interface
  always_comb begin
    fb_busy    = r_busy;
    disp_valid = w_out_valid;
    disp_px    = w_out_data[c_aw+c_dw-1:c_dw];
    disp_r     = w_out_data[c_dw-1:2*COLOR_BITS];
    disp_g     = w_out_data[2*COLOR_BITS-1:COLOR_BITS];
    disp_b     = w_out_data[COLOR_BITS-1:0];
    disp_last  = w_out_valid && (disp_px == {c_aw{1'b1}});
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buffer
// Description : Directed bench for frame_buffer on a 16x16 frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buffer;

  localparam int XB = 4;
  localparam int YB = 4;
  localparam int CB = 8;
  localparam int AW = XB + YB;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fb_wfb = 1'b0;
  logic          fb_dfb = 1'b0;
  logic [AW-1:0] fb_px = '0;
  logic [CB-1:0] fb_r = '0, fb_g = '0, fb_b = '0;
  logic          disp_ready = 1'b0;
  logic          fb_busy, disp_valid, disp_last;
  logic [AW-1:0] disp_px;
  logic [CB-1:0] disp_r, disp_g, disp_b;

  always #5 clk = ~clk;

  frame_buffer #(.X_BITS(XB), .Y_BITS(YB), .COLOR_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .fb_wfb(fb_wfb), .fb_dfb(fb_dfb), .fb_px(fb_px),
    .fb_r(fb_r), .fb_g(fb_g), .fb_b(fb_b), .fb_busy(fb_busy),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_px(disp_px),
    .disp_r(disp_r), .disp_g(disp_g), .disp_b(disp_b), .disp_last(disp_last)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   rgb;
    int            cycle;
    logic          last;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] exp_mem  [N];
  logic [23:0] dump_exp [N];
  int          pres_cycle [N];
  logic [23:0] pres_rgb   [N];
  logic        pres_last  [N];
  int          hs_count;
  int          busy_cycles;
  vec_t        vec [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic write_px(input logic [AW-1:0] a, input logic [23:0] d);
    @(negedge clk);
    fb_wfb = 1'b1;
    fb_px  = a;
    {fb_r, fb_g, fb_b} = d;
    exp_mem[a] = d;
  endtask

  task automatic idle_cycles(input int n, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fb_wfb = 1'b0;
      fb_dfb = 1'b0;
      #1;
      if (disp_valid || fb_busy) bad++;
    end
    check(name, 64'(bad), 64'd0);
  endtask

  // mode 0: ready always 1; mode 1: ready pattern 1,0,0,1
  task automatic run_dump(input int mode, input int ign_at, input int wr_at,
                          input logic [AW-1:0] wr_a, input logic [23:0] wr_d,
                          input int rst_at, input bit co_wr, input logic [23:0] co_d);
    bit          done, aborted, ign_done, wr_done, pv, pr;
    logic [AW-1:0] ppx;
    logic [23:0] prgb;
    int          c;
    done = 0; aborted = 0; ign_done = 0; wr_done = 0; pv = 0; pr = 0;
    ppx = '0; prgb = '0;
    hs_count = 0;
    busy_cycles = 0;
    for (int i = 0; i < N; i++) pres_cycle[i] = -1;
    @(negedge clk);
    fb_dfb = 1'b1;
    disp_ready = 1'b1;
    if (co_wr) begin
      fb_wfb = 1'b1;
      fb_px  = '0;
      {fb_r, fb_g, fb_b} = co_d;
      exp_mem[0] = co_d;
    end
    #1;
    check("busy_before_start", 64'(fb_busy), 64'd0);
    c = 1;
    while (c < 4 * N + 20 && !done) begin
      @(negedge clk);
      fb_dfb = 1'b0;
      fb_wfb = 1'b0;
      disp_ready = (mode == 0) ? 1'b1 : ((c % 4 == 1) || (c % 4 == 0));
      if (!ign_done && hs_count == ign_at) begin
        fb_dfb = 1'b1;
        ign_done = 1;
      end
      if (!wr_done && hs_count == wr_at) begin
        fb_wfb = 1'b1;
        fb_px  = wr_a;
        {fb_r, fb_g, fb_b} = wr_d;
        exp_mem[wr_a] = wr_d;
        wr_done = 1;
      end
      if (hs_count == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("reset_outputs",
              64'({fb_busy, disp_valid, disp_last, disp_px, disp_r, disp_g, disp_b}), 64'd0);
        aborted = 1;
        done = 1;
      end else begin
        #1;
        if (c == 1) check("busy_rise", 64'(fb_busy), 64'd1);
        if (fb_busy) busy_cycles++;
        if (pv && !pr)
          check("hold_stable", 64'({disp_valid, disp_px, disp_r, disp_g, disp_b}),
                64'({1'b1, ppx, prgb}));
        if (disp_valid && pres_cycle[disp_px] < 0) begin
          pres_cycle[disp_px] = c;
          pres_rgb[disp_px]   = {disp_r, disp_g, disp_b};
          pres_last[disp_px]  = disp_last;
        end
        if (disp_valid && disp_ready) begin
          if (hs_count < N)
            check("pixel", 64'({disp_px, disp_r, disp_g, disp_b, disp_last}),
                  64'({hs_count[AW-1:0], dump_exp[hs_count], hs_count == N - 1}));
          else
            check("extra_pixel", 64'(hs_count), 64'(N - 1));
          hs_count++;
        end
        pv = disp_valid;
        pr = disp_ready;
        ppx = disp_px;
        prgb = {disp_r, disp_g, disp_b};
        if (!fb_busy && c > 1) done = 1;
        c++;
      end
    end
    if (!aborted) begin
      check("dump_finished", 64'(done), 64'd1);
      check("handshakes", 64'(hs_count), 64'(N));
      if (mode == 0) check("busy_cycles", 64'(busy_cycles), 64'(N + 1));
      idle_cycles(8, "quiet_after_dump");
    end
  endtask

  initial begin
    vec[0] = '{addr: 8'h00, rgb: 24'hFF0000, cycle: 2,     last: 1'b0};
    vec[1] = '{addr: 8'h0F, rgb: 24'h00FF00, cycle: 17,    last: 1'b0};
    vec[2] = '{addr: 8'hFF, rgb: 24'h0000FF, cycle: N + 1, last: 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", 64'({fb_busy, disp_valid, disp_last, disp_px, disp_r, disp_g, disp_b}),
          64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill the whole frame with a known pattern, then the table pixels
    for (int a = 0; a < N; a++) write_px(8'(a), {8'(a), ~8'(a), 8'(a) ^ 8'h5A});
    for (int i = 0; i < 3; i++) write_px(vec[i].addr, vec[i].rgb);
    idle_cycles(2, "idle_before_dump");

    // Full-rate dump; table pixels presented at fixed cycles
    dump_exp = exp_mem;
    run_dump(0, -1, -1, '0, '0, -1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      check("table_cycle", 64'(pres_cycle[vec[i].addr]), 64'(vec[i].cycle));
      check("table_rgb_last", 64'({pres_rgb[vec[i].addr], pres_last[vec[i].addr]}),
            64'({vec[i].rgb, vec[i].last}));
    end

    // Backpressure pattern 1,0,0,1
    dump_exp = exp_mem;
    run_dump(1, -1, -1, '0, '0, -1, 1'b0, '0);

    // Second fb_dfb mid-dump is ignored
    dump_exp = exp_mem;
    run_dump(0, 100, -1, '0, '0, -1, 1'b0, '0);

    // Write to a not-yet-read address during dump shows up now
    dump_exp = exp_mem;
    dump_exp[8'h80] = 24'h123456;
    run_dump(0, -1, 10, 8'h80, 24'h123456, -1, 1'b0, '0);

    // Write to an already-read address shows old value now, new value next dump
    dump_exp = exp_mem;
    run_dump(0, -1, 10, 8'h05, 24'hABCDEF, -1, 1'b0, '0);
    dump_exp = exp_mem;
    run_dump(0, -1, -1, '0, '0, -1, 1'b0, '0);
    check("late_write_next_dump", 64'(pres_rgb[5]), 64'h00ABCDEF);

    // Write and dump start in the same cycle
    dump_exp = exp_mem;
    dump_exp[0] = 24'h777777;
    run_dump(0, -1, -1, '0, '0, -1, 1'b1, 24'h777777);
    check("co_write_first_px", 64'(pres_rgb[0]), 64'h00777777);

    // Reset mid-dump, then no output until a new dump; contents retained
    dump_exp = exp_mem;
    run_dump(0, -1, -1, '0, '0, 100, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(20, "quiet_after_reset");
    dump_exp = exp_mem;
    run_dump(0, -1, -1, '0, '0, -1, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
